// File: rtl/c2c_master01.sv
// Serial chip-to-chip bus master: one command/address/data frame per request,
// single-lane or quad-lane, SPI mode 0 clocking derived from the system clock.
module c2c_master01 #(
    parameter int CLK_DIV      = 2,
    parameter int DUMMY_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rstp,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        quad_mode,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        c2cm_clk,
    output logic        c2cm_csn,
    output logic [3:0]  c2cm_dq_o,
    output logic [3:0]  c2cm_dq_oe,
    input  logic [3:0]  c2cm_dq_i
);

    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MAX_BEATS = (DUMMY_CYCLES > 32) ? DUMMY_CYCLES : 32;
    localparam int BEAT_W    = $clog2(MAX_BEATS + 1);

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        DUMMY,
        RDATA,
        GAP
    } state_t;

    state_t state, state_next;

    logic [DIV_W-1:0]  div_cnt;
    logic              half;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beats;

    logic        wr_q;
    logic        quad_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] tx_sh;
    logic [31:0] rx_sh;

    logic accept;
    logic active;
    logic div_end;
    logic rise;
    logic beat_end;
    logic last_beat;
    logic frame_end;

    // Beats in the current phase; GAP is timed as one clock-less beat.
    always_comb begin
        case (state)
            CMD:                beats = quad_q ? BEAT_W'(2) : BEAT_W'(8);
            ADDR, WDATA, RDATA: beats = quad_q ? BEAT_W'(8) : BEAT_W'(32);
            DUMMY:              beats = BEAT_W'(DUMMY_CYCLES);
            default:            beats = BEAT_W'(1);
        endcase
    end

    assign accept    = req_valid && req_ready;
    assign active    = (state == CMD) || (state == ADDR) || (state == WDATA) ||
                       (state == DUMMY) || (state == RDATA);
    assign div_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise      = active && !half && div_end;
    assign beat_end  = (state != IDLE) && half && div_end;
    assign last_beat = (beat_cnt == beats - BEAT_W'(1));
    assign frame_end = beat_end && last_beat && ((state == WDATA) || (state == RDATA));

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        c2cm_dq_oe = 4'b0000;
        c2cm_dq_o  = 4'b0000;
        case (state)
            IDLE: begin
                req_ready = !rstp;
                if (req_valid && !rstp) begin
                    state_next = CMD;
                end
            end
            CMD: begin
                if (beat_end && last_beat) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (beat_end && last_beat) begin
                    if (wr_q) begin
                        state_next = WDATA;
                    end else if (DUMMY_CYCLES > 0) begin
                        state_next = DUMMY;
                    end else begin
                        state_next = RDATA;
                    end
                end
            end
            WDATA, RDATA: begin
                if (beat_end && last_beat) begin
                    state_next = GAP;
                end
            end
            DUMMY: begin
                if (beat_end && last_beat) begin
                    state_next = RDATA;
                end
            end
            GAP: begin
                if (beat_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Master owns the lanes only while shifting out command, address or write data.
        if ((state == CMD) || (state == ADDR) || (state == WDATA)) begin
            c2cm_dq_oe = quad_q ? 4'b1111 : 4'b0001;
            c2cm_dq_o  = quad_q ? tx_sh[31:28] : {3'b000, tx_sh[31]};
        end
    end

    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            div_cnt    <= '0;
            half       <= 1'b0;
            beat_cnt   <= '0;
            c2cm_clk   <= 1'b0;
            c2cm_csn   <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            if (accept) begin
                div_cnt  <= '0;
                half     <= 1'b0;
                beat_cnt <= '0;
                c2cm_clk <= 1'b0;
                c2cm_csn <= 1'b0;
            end else if (state != IDLE) begin
                if (div_end) begin
                    div_cnt <= '0;
                    half    <= !half;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
                if (rise) begin
                    c2cm_clk <= 1'b1;
                end else if (beat_end) begin
                    c2cm_clk <= 1'b0;
                end
                if (beat_end) begin
                    beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
                end
                if (frame_end) begin
                    c2cm_csn   <= 1'b1;
                    resp_valid <= 1'b1;
                    resp_rdata <= wr_q ? 32'h0 : rx_sh;
                end
            end
        end
    end

    // Request fields and shift registers: only meaningful inside a frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_write;
            quad_q  <= quad_mode;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            tx_sh   <= {(req_write ? CMD_WRITE : CMD_READ), 24'h000000};
            rx_sh   <= '0;
        end else begin
            if (rise && (state == RDATA)) begin
                rx_sh <= quad_q ? {rx_sh[27:0], c2cm_dq_i} : {rx_sh[30:0], c2cm_dq_i[1]};
            end
            if (beat_end && active) begin
                if (last_beat) begin
                    if (state == CMD) begin
                        tx_sh <= addr_q;
                    end else if (state == ADDR) begin
                        tx_sh <= wdata_q;
                    end
                end else begin
                    tx_sh <= quad_q ? {tx_sh[27:0], 4'h0} : {tx_sh[30:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_c2c_master01.sv
// Bench for c2c_master01: a slave-side monitor records every beat and is compared
// against a frame built directly from the command/address/data rules.
module tb_c2c_master01;

    logic        clk = 1'b0;
    logic        rstp = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        req_quad = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  dq_i = '0;

    logic        vin0, rdy0, rv0, ck0, cs0;
    logic [31:0] rd0;
    logic [3:0]  o0, oe0;
    logic        vin1, rdy1, rv1, ck1, cs1;
    logic [31:0] rd1;
    logic [3:0]  o1, oe1;

    logic        m_ready, m_rv, m_clk, m_csn;
    logic [31:0] m_rdata;
    logic [3:0]  m_o, m_oe;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign vin0    = req_valid & ~sel;
    assign vin1    = req_valid & sel;
    assign m_ready = sel ? rdy1 : rdy0;
    assign m_rv    = sel ? rv1 : rv0;
    assign m_clk   = sel ? ck1 : ck0;
    assign m_csn   = sel ? cs1 : cs0;
    assign m_rdata = sel ? rd1 : rd0;
    assign m_o     = sel ? o1 : o0;
    assign m_oe    = sel ? oe1 : oe0;

    c2c_master01 #(.CLK_DIV(2), .DUMMY_CYCLES(32)) dut0 (
        .clk(clk), .rstp(rstp), .req_valid(vin0), .req_ready(rdy0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .quad_mode(req_quad), .resp_valid(rv0), .resp_rdata(rd0),
        .c2cm_clk(ck0), .c2cm_csn(cs0), .c2cm_dq_o(o0), .c2cm_dq_oe(oe0),
        .c2cm_dq_i(dq_i)
    );

    c2c_master01 #(.CLK_DIV(1), .DUMMY_CYCLES(4)) dut1 (
        .clk(clk), .rstp(rstp), .req_valid(vin1), .req_ready(rdy1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .quad_mode(req_quad), .resp_valid(rv1), .resp_rdata(rd1),
        .c2cm_clk(ck1), .c2cm_csn(cs1), .c2cm_dq_o(o1), .c2cm_dq_oe(oe1),
        .c2cm_dq_i(dq_i)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected {oe, dq_o} per beat: the frame's bits peeled off MSB first, then idle lanes.
    task automatic build_exp(input bit wr, input bit quad, input logic [31:0] addr,
                             input logic [31:0] wdata, input int dmy);
        logic [71:0] frame;
        logic [71:0] sh;
        int lane, ntx;
        exp_q.delete();
        frame = {(wr ? 8'h02 : 8'h0B), addr, wdata};
        lane  = quad ? 4 : 1;
        ntx   = (wr ? 72 : 40) / lane;
        for (int i = 0; i < ntx; i++) begin
            sh = frame >> (72 - lane * (i + 1));
            if (quad) exp_q.push_back({4'hF, sh[3:0]});
            else      exp_q.push_back({4'h1, 3'b000, sh[0]});
        end
        if (!wr) begin
            for (int i = 0; i < dmy + 32 / lane; i++) exp_q.push_back(8'h00);
        end
    endtask

    task automatic issue(input bit wr, input bit quad, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        req_write = wr;
        req_quad  = quad;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        while (!m_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready seen", m_ready, 1);
        @(posedge clk);
        #1;
        if (!hold) begin
            req_valid = 1'b0;
            req_write = 1'($urandom);
            req_quad  = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
        end
    endtask

    // Acts as the slave for one frame starting right after acceptance; returns at the response.
    task automatic collect(input bit wr, input bit quad, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] sdata, input string tag);
        int c, dmy, budget, rises, csn_low, idle_bad, hi_bad, hi_run, bad, rs, nrd, k;
        bit prev_clk, got_resp;
        logic [7:0] got_q[$];
        c   = sel ? 1 : 2;
        dmy = sel ? 4 : 32;
        build_exp(wr, quad, addr, wdata, dmy);
        rs  = (quad ? 10 : 40) + dmy;
        nrd = quad ? 8 : 32;
        rises = 0; csn_low = 0; idle_bad = 0; hi_bad = 0; hi_run = 0;
        prev_clk = 1'b0; got_resp = 1'b0;
        budget = 2 * c * (exp_q.size() + 4) + 20;
        for (int cyc = 0; cyc < budget && !got_resp; cyc++) begin
            @(negedge clk);
            if (!m_csn) csn_low++;
            if (m_clk) hi_run++;
            if (m_clk && !prev_clk) begin
                got_q.push_back({m_oe, m_o});
                rises++;
            end
            if (!m_clk && prev_clk) begin
                if (hi_run != c) hi_bad++;
                hi_run = 0;
            end
            if (m_csn && (m_clk || m_oe != 4'h0 || m_o != 4'h0)) idle_bad++;
            if ((m_o & ~m_oe) != 4'h0) idle_bad++;
            k = rises - rs;
            if (!wr && k >= 0 && k < nrd) begin
                if (quad) dq_i = 4'(sdata >> (28 - 4 * k));
                else begin
                    dq_i    = 4'($urandom);
                    dq_i[1] = sdata[31 - k];
                end
            end else begin
                dq_i = 4'($urandom);
            end
            if (m_rv) got_resp = 1'b1;
            prev_clk = m_clk;
        end
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) bad++;
        end
        chk({tag, " resp_valid"}, got_resp, 1);
        chk({tag, " beats"}, rises, exp_q.size());
        chk({tag, " lane mismatches"}, bad, 0);
        chk({tag, " csn low cycles"}, csn_low, exp_q.size() * 2 * c);
        chk({tag, " resp_rdata"}, m_rdata, wr ? 32'h0 : sdata);
        chk({tag, " idle bus violations"}, idle_bad, 0);
        chk({tag, " clk high-half errors"}, hi_bad, 0);
    endtask

    task automatic txn(input bit wr, input bit quad, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] sdata, input string tag);
        issue(wr, quad, addr, wdata, 1'b0);
        collect(wr, quad, addr, wdata, sdata, tag);
        @(negedge clk);
        chk({tag, " single pulse"}, m_rv, 0);
    endtask

    initial begin
        int rises, gap, extra, csn_bad;
        bit prev, rv_seen;
        logic [31:0] a, d;

        repeat (3) @(negedge clk);
        chk("rst req_ready", m_ready, 0);
        chk("rst csn", m_csn, 1);
        chk("rst clk", m_clk, 0);
        chk("rst dq_oe", m_oe, 0);
        chk("rst dq_o", m_o, 0);
        chk("rst resp_valid", m_rv, 0);
        chk("rst resp_rdata", m_rdata, 0);
        rstp = 1'b0;
        #1;
        chk("ready after release", m_ready, 1);

        txn(1'b1, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, "wr_single");
        txn(1'b0, 1'b1, 32'h0000_0040, $urandom, 32'h1234_5678, "rd_quad");
        txn(1'b0, 1'b0, $urandom, $urandom, 32'hA5A5_A5A5, "rd_single");

        // Reset during address beat 10 of a write.
        issue(1'b1, 1'b0, 32'hCAFE_0000, 32'h5555_AAAA, 1'b0);
        rises = 0;
        prev  = 1'b0;
        for (int cyc = 0; cyc < 400 && rises < 18; cyc++) begin
            @(negedge clk);
            if (m_clk && !prev) rises++;
            prev = m_clk;
        end
        chk("abort beat reached", rises, 18);
        #2 rstp = 1'b1;
        #1;
        chk("abort csn", m_csn, 1);
        chk("abort clk", m_clk, 0);
        chk("abort dq_oe", m_oe, 0);
        chk("abort dq_o", m_o, 0);
        chk("abort resp_rdata", m_rdata, 0);
        chk("abort req_ready", m_ready, 0);
        rv_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            rv_seen |= m_rv;
        end
        rstp = 1'b0;
        repeat (10) begin
            @(negedge clk);
            rv_seen |= m_rv;
        end
        chk("abort no response", rv_seen, 0);
        txn(1'b1, 1'b0, 32'h0000_1234, 32'h8765_4321, 32'h0, "after_abort");

        for (int t = 0; t < 5; t++) begin
            txn(1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, "random");
        end

        // Back-to-back with req_valid held high.
        a = $urandom;
        d = $urandom;
        issue(1'b1, 1'b1, a, d, 1'b1);
        collect(1'b1, 1'b1, a, d, 32'h0, "b2b first");
        gap = 0; extra = 0; csn_bad = 0;
        while (!m_ready && gap < 20) begin
            if (!m_csn) csn_bad++;
            @(negedge clk);
            gap++;
            if (m_rv) extra++;
        end
        chk("b2b accept distance", gap, 4);
        chk("b2b csn high between", csn_bad, 0);
        chk("b2b extra resp", extra, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        collect(1'b1, 1'b1, a, d, 32'h0, "b2b second");

        sel = 1'b1;
        txn(1'b1, 1'b1, $urandom, 32'hFFFF_0000, 32'h0, "wr_quad_div1");
        txn(1'b0, 1'b1, $urandom, $urandom, $urandom, "rd_quad_div1");
        txn(1'b0, 1'b0, $urandom, $urandom, $urandom, "rd_single_div1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
